// File: rtl/button_cmd_scheduler.sv
// button_cmd_scheduler
//   Holds one-cycle press pulses from NUM_BTN debouncers as pending requests and
//   issues them one at a time, in round-robin order, to a single command consumer.
//
//   Handshake: a command transfers on every rising edge where cmd_valid and
//   cmd_ready are both 1. Once cmd_valid is raised, it and cmd_id stay stable
//   until that transfer happens; only flush or reset can withdraw them. cmd_ready
//   has no effect while cmd_valid is 0.
module button_cmd_scheduler #(
   parameter int NUM_BTN = 4,
   parameter int ID_W    = 2,
   parameter int DROP_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] press,
   input  logic               flush,
   output logic               cmd_valid,
   input  logic               cmd_ready,
   output logic [ID_W-1:0]    cmd_id,
   output logic               busy,
   output logic [DROP_W-1:0]  drop_count,
   output logic [0:0]         dbg_state
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_OFFER = 1'b1;

   logic [0:0]         state, state_nxt;
   logic [NUM_BTN-1:0] pending, pending_nxt;
   logic [ID_W-1:0]    rr_ptr, rr_nxt;
   logic [ID_W-1:0]    cmd_id_nxt;
   logic               busy_nxt;
   logic [DROP_W-1:0]  drop_nxt;

   logic               accept;
   logic [NUM_BTN-1:0] acc_mask;
   logic [NUM_BTN-1:0] cand;
   logic               drop_hit;
   logic               load;
   logic               sel_found;
   logic [ID_W-1:0]    sel_idx;

   // cmd_valid is a pure decode of the state register, so it is glitch-free.
   assign cmd_valid = (state == S_OFFER);
   assign dbg_state = state;

   // Accept decode: which pending bit is consumed this cycle, and presses that collide with a still-pending request.
   always_comb begin
      accept   = cmd_valid & cmd_ready;
      acc_mask = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         acc_mask[i] = accept && (cmd_id == ID_W'(i));
      end
      // A press on the button being accepted is a fresh request, not a drop.
      cand     = pending & ~acc_mask;
      drop_hit = |(press & cand);
   end

   // Round-robin pick: first candidate at or after rr_ptr, wrapping at NUM_BTN-1.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_BTN;
         if (!sel_found && cand[idx]) begin
            sel_found = 1'b1;
            sel_idx   = ID_W'(idx);
         end
      end
   end

   // Next-state logic for the FSM, request set, pointer, busy and drop counter.
   always_comb begin
      // Reload happens from IDLE, or back-to-back on an accept while in OFFER.
      load        = sel_found && ((state == S_IDLE) || accept);
      state_nxt   = state;
      cmd_id_nxt  = cmd_id;
      rr_nxt      = rr_ptr;
      pending_nxt = cand | press;
      drop_nxt    = drop_count;

      if (load) begin
         state_nxt  = S_OFFER;
         cmd_id_nxt = sel_idx;
         rr_nxt     = (sel_idx == ID_W'(NUM_BTN - 1)) ? '0 : sel_idx + 1'b1;
      end else if (accept) begin
         state_nxt = S_IDLE;
      end

      if (drop_hit && (drop_count != '1)) begin
         drop_nxt = drop_count + 1'b1;
      end

      // Flush wins over everything; pointer, id and drop history are kept.
      if (flush) begin
         state_nxt   = S_IDLE;
         pending_nxt = '0;
         cmd_id_nxt  = cmd_id;
         rr_nxt      = rr_ptr;
         drop_nxt    = drop_count;
      end

      busy_nxt = (|pending_nxt) | (state_nxt == S_OFFER);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pending    <= '0;
         cmd_id     <= '0;
         rr_ptr     <= '0;
         busy       <= 1'b0;
         drop_count <= '0;
      end else begin
         state      <= state_nxt;
         pending    <= pending_nxt;
         cmd_id     <= cmd_id_nxt;
         rr_ptr     <= rr_nxt;
         busy       <= busy_nxt;
         drop_count <= drop_nxt;
      end
   end

endmodule
